// File: rtl/dff_pipe_pkg.sv
// dff_pipe_pkg: shared helpers for the dff_pipe elastic pipeline.
// Holds the count-width derivation and the data reset value.
package dff_pipe_pkg;

  localparam logic DATA_RST_BIT = 1'b0;

  function automatic int cnt_width(int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// dff_pipe_stage: one valid/data register of the elastic pipeline.
// Clear drops the valid bit only; the data bits are kept.
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  output logic [WIDTH-1:0] o_data
);

  logic             r_vld;
  logic [WIDTH-1:0] r_data;

  // Capture the upstream word when loading, drop valid on clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= 1'b0;
      r_data <= {WIDTH{DATA_RST_BIT}};
    end else if (i_clr) begin
      r_vld  <= 1'b0;
    end else if (i_load) begin
      r_vld  <= i_vld;
      r_data <= i_data;
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;

endmodule

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage elastic register pipeline.
// Optional synchronous flush port clr with DFF_PIPE_CLR_EN.
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef DFF_PIPE_CLR_EN
  input  logic             clr,
`endif
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] w_vld;
  logic [WIDTH-1:0] w_data [DEPTH];
  logic [DEPTH-1:0] w_rdy;
  logic             w_clr;
  logic             w_acc;
  logic             w_pop;
  logic [CNT_W-1:0] r_count;

`ifdef DFF_PIPE_CLR_EN
  assign w_clr = clr;
`else
  assign w_clr = 1'b0;
`endif

  // A stage may load if it or any stage after it is free,
  // or if the consumer is taking the last word
  always_comb begin
    logic w_free;
    w_rdy  = '0;
    w_free = q_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_free   = w_free || !w_vld[i];
      w_rdy[i] = w_free;
    end
  end

  assign din_ready = w_rdy[0] && !w_clr;
  assign q_valid   = w_vld[DEPTH-1] && !w_clr;
  assign q         = w_data[DEPTH-1];
  assign q_bar     = ~w_data[DEPTH-1];
  assign w_acc     = din_valid && din_ready;
  assign w_pop     = q_valid && q_ready;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic             w_src_vld;
    logic [WIDTH-1:0] w_src_data;

    if (gi == 0) begin : g_head
      assign w_src_vld  = din_valid;
      assign w_src_data = din;
    end else begin : g_body
      assign w_src_vld  = w_vld[gi-1];
      assign w_src_data = w_data[gi-1];
    end

    dff_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .i_load (w_rdy[gi]),
      .i_vld  (w_src_vld),
      .i_data (w_src_data),
      .o_vld  (w_vld[gi]),
      .o_data (w_data[gi])
    );
  end

  // Occupancy tracks accepts minus pops; flush empties it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_clr) begin
      r_count <= '0;
    end else if (w_acc && !w_pop) begin
      r_count <= r_count + CNT_W'(1);
    end else if (!w_acc && w_pop) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: scoreboard bench for dff_pipe (WIDTH=8, DEPTH=4).
// Directed scenarios plus a randomized handshake phase.
module tb_dff_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             q_valid;
  logic             q_ready;
  logic [CNT_W-1:0] count;
`ifdef DFF_PIPE_CLR_EN
  logic             clr = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               mcount = 0;
  bit               hold_prev = 1'b0;
  logic [WIDTH-1:0] q_prev;

  always #5 clk = ~clk;

  dff_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef DFF_PIPE_CLR_EN
    .clr       (clr),
`endif
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .q         (q),
    .q_bar     (q_bar),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .count     (count)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit clr_now();
`ifdef DFF_PIPE_CLR_EN
    return clr;
`else
    return 1'b0;
`endif
  endfunction

  // Feed side: every accepted word is the next expected output
  always @(negedge clk) begin
    if (!rst && din_valid && din_ready)
      exp_q.push_back(din);
  end

  // Monitor side: compare popped words and occupancy against the model
  always @(negedge clk) begin
    logic [WIDTH-1:0] nq;
    logic [WIDTH-1:0] ev;
    bit acc;
    bit pop;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      nq = ~q;
      chk("q_bar", {24'h0, q_bar}, {24'h0, nq});
      chk("count", {29'h0, count}, mcount);
      chk("din_ready", {31'h0, din_ready},
          {31'h0, ((mcount < DEPTH) || q_ready) && !clr_now()});
      if (hold_prev && !clr_now()) begin
        chk("hold_valid", {31'h0, q_valid}, 32'h1);
        chk("hold_data", {24'h0, q}, {24'h0, q_prev});
      end
      acc = din_valid && din_ready;
      pop = q_valid && q_ready;
      if (pop) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL q_data: got 0x%0h, expected nothing @%0t",
                   q, $time);
        end else begin
          ev = exp_q.pop_front();
          chk("q_data", {24'h0, q}, {24'h0, ev});
        end
      end
      if (acc && !pop) mcount++;
      if (pop && !acc) mcount--;
      if (clr_now()) begin
        mcount = 0;
        exp_q.delete();
      end
      hold_prev = q_valid && !q_ready;
      q_prev    = q;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] w);
    bit ok;
    ok        = 1'b0;
    din       = w;
    din_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (din_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send_accept", {31'h0, ok}, 32'h1);
    tick();
    din_valid = 1'b0;
  endtask

  task automatic wait_empty();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (count == 0 && !q_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", {31'h0, ok}, 32'h1);
    chk("sb_empty", exp_q.size(), 32'h0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] bp [5];
    bp = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};
    din       = '0;
    din_valid = 1'b0;
    q_ready   = 1'b0;

    #1 rst = 1'b1;
    #2;
    chk("rst_q_valid", {31'h0, q_valid}, 32'h0);
    chk("rst_q", {24'h0, q}, 32'h0);
    chk("rst_q_bar", {24'h0, q_bar}, 32'hFF);
    chk("rst_count", {29'h0, count}, 32'h0);
    chk("rst_din_ready", {31'h0, din_ready}, 32'h1);
    tick();
    rst = 1'b0;

    // latency and order
    q_ready   = 1'b1;
    din_valid = 1'b1;
    din       = 8'hA5;
    tick();
    din = 8'h3C;
    tick();
    din = 8'h0F;
    tick();
    din_valid = 1'b0;
    @(negedge clk);
    chk("lat_early", {31'h0, q_valid}, 32'h0);
    tick();
    @(negedge clk);
    chk("lat_v0", {31'h0, q_valid}, 32'h1);
    chk("lat_q0", {24'h0, q}, 32'hA5);
    chk("lat_qb0", {24'h0, q_bar}, 32'h5A);
    tick();
    @(negedge clk);
    chk("lat_q1", {24'h0, q}, 32'h3C);
    chk("lat_qb1", {24'h0, q_bar}, 32'hC3);
    tick();
    @(negedge clk);
    chk("lat_q2", {24'h0, q}, 32'h0F);
    chk("lat_qb2", {24'h0, q_bar}, 32'hF0);
    tick();
    @(negedge clk);
    chk("lat_end", {31'h0, q_valid}, 32'h0);
    tick();

    // back-pressure
    q_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++) send(bp[k]);
      end
      begin
        repeat (8) @(posedge clk);
        #2;
        chk("bp_count", {29'h0, count}, 32'd4);
        chk("bp_din_ready", {31'h0, din_ready}, 32'h0);
        q_ready = 1'b1;
      end
    join
    wait_empty();

    // full push and pop
    q_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(WIDTH'($urandom));
    @(negedge clk);
    chk("full_count", {29'h0, count}, 32'd4);
    tick();
    q_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      din       = WIDTH'($urandom);
      din_valid = 1'b1;
      @(negedge clk);
      chk("pp_count", {29'h0, count}, 32'd4);
      chk("pp_ready", {31'h0, din_ready}, 32'h1);
      chk("pp_valid", {31'h0, q_valid}, 32'h1);
      tick();
    end
    din_valid = 1'b0;
    wait_empty();

    // bubble collapse
    q_ready   = 1'b0;
    din       = 8'hB1;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    tick();
    din       = 8'hB2;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("bub_count", {29'h0, count}, 32'd2);
    chk("bub_q", {24'h0, q}, 32'hB1);
    chk("bub_ready", {31'h0, din_ready}, 32'h1);
    tick();
    q_ready = 1'b1;
    tick();
    q_ready = 1'b0;
    @(negedge clk);
    chk("bub_next_v", {31'h0, q_valid}, 32'h1);
    chk("bub_next_q", {24'h0, q}, 32'hB2);
    tick();
    q_ready = 1'b1;
    wait_empty();

    // randomized handshake
    for (int k = 0; k < 400; k++) begin
      din       = WIDTH'($urandom);
      din_valid = ($urandom_range(0, 3) != 0);
      q_ready   = ($urandom_range(0, 2) != 0);
      tick();
    end
    din_valid = 1'b0;
    q_ready   = 1'b1;
    wait_empty();

    // reset mid-stream with three words held
    q_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(WIDTH'($urandom));
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mrst_q_valid", {31'h0, q_valid}, 32'h0);
    chk("mrst_q", {24'h0, q}, 32'h0);
    chk("mrst_q_bar", {24'h0, q_bar}, 32'hFF);
    chk("mrst_count", {29'h0, count}, 32'h0);
    chk("mrst_din_ready", {31'h0, din_ready}, 32'h1);
    exp_q.delete();
    mcount = 0;
    tick();
    rst = 1'b0;
    tick();

`ifdef DFF_PIPE_CLR_EN
    q_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(WIDTH'($urandom));
    din       = 8'h77;
    din_valid = 1'b1;
    clr       = 1'b1;
    @(negedge clk);
    chk("clr_ready", {31'h0, din_ready}, 32'h0);
    chk("clr_valid", {31'h0, q_valid}, 32'h0);
    tick();
    clr       = 1'b0;
    din_valid = 1'b0;
    @(negedge clk);
    chk("clr_count", {29'h0, count}, 32'h0);
    chk("clr_q_valid", {31'h0, q_valid}, 32'h0);
    tick();
    q_ready   = 1'b1;
    din       = 8'h11;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("clr_lat_early", {31'h0, q_valid}, 32'h0);
    tick();
    @(negedge clk);
    chk("clr_lat_v", {31'h0, q_valid}, 32'h1);
    chk("clr_lat_q", {24'h0, q}, 32'h11);
    tick();
    @(negedge clk);
    chk("clr_alone", {31'h0, q_valid}, 32'h0);
    wait_empty();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
